// File: rtl/adder_checker_pkg.sv
// Shared definitions for the full-adder sweep checker: FSM state encoding,
// vector count and the golden sum/carry functions.
package adder_checker_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int          NUM_VEC  = 8;
    localparam logic [2:0]  LAST_VEC = 3'(NUM_VEC - 1);

    // Golden sum bit of a one-bit full adder.
    function automatic logic exp_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    // Golden carry-out: majority of the three inputs.
    function automatic logic exp_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (a & cin) | (b & cin);
    endfunction

endpackage

// File: rtl/adder_checker_ref.sv
// Reference model: derives the expected full-adder response from the
// vector currently driven onto the adder under test ({cin,b,a}).
module adder_checker_ref
    import adder_checker_pkg::*;
(
    input  logic [2:0] vec,
    output logic       sum,
    output logic       carry
);

    assign sum   = exp_sum(vec[0], vec[1], vec[2]);
    assign carry = exp_carry(vec[0], vec[1], vec[2]);

endmodule

// File: rtl/adder_checker.sv
// Exhaustive full-adder checker. On start it walks vectors 0..7, holds each
// for SETTLE_CYC cycles after applying it, then compares the adder response
// with the reference and accumulates a mismatch count and first-fail index.
// Optional build macro ADDER_CHECKER_STOP_ON_FAIL_EN ends the sweep at the
// first mismatch.
module adder_checker
    import adder_checker_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_cin,
    input  logic       dut_sum,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_vec
);

    // Last value of the settle counter before moving on to CHECK.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

    state_t     state_r, state_s;
    logic [2:0] vec_r,   vec_s;
    logic [3:0] cnt_r,   cnt_s;
    logic [3:0] err_r,   err_s;
    logic [2:0] fv_r,    fv_s;
    logic [2:0] stim_r,  stim_s;
    logic       busy_r,  busy_s;
    logic       done_r,  done_s;
    logic       pass_r,  pass_s;

    logic       ref_sum_s;
    logic       ref_carry_s;
    logic       mismatch_s;

    // Expected response is derived from the registered stimulus so it lines
    // up exactly with what the adder is seeing.
    adder_checker_ref u_ref (
        .vec   (stim_r),
        .sum   (ref_sum_s),
        .carry (ref_carry_s)
    );

    assign mismatch_s = (dut_sum != ref_sum_s) | (dut_c != ref_carry_s);

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        fv_s    = fv_r;
        stim_s  = stim_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = APPLY;
                    vec_s   = 3'd0;
                    cnt_s   = 4'd0;
                    err_s   = 4'd0;
                    fv_s    = 3'd0;
                    stim_s  = 3'd0;
                end else begin
                    stim_s  = 3'd0;
                end
            end
            APPLY: begin
                cnt_s = 4'd0;
                if (SETTLE_CYC == 0) begin
                    state_s = CHECK;
                end else begin
                    state_s = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = CHECK;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch_s) begin
                    err_s = err_r + 4'd1;
                    // A zero count means this is the first failure of the sweep.
                    if (err_r == 4'd0) begin
                        fv_s = vec_r;
                    end else begin
                        fv_s = fv_r;
                    end
                end else begin
                    err_s = err_r;
                end
`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
                if (mismatch_s || (vec_r == LAST_VEC)) begin
                    state_s = DONE;
                    stim_s  = 3'd0;
                end else begin
                    state_s = APPLY;
                    vec_s   = vec_r + 3'd1;
                    stim_s  = vec_r + 3'd1;
                end
`else
                if (vec_r == LAST_VEC) begin
                    state_s = DONE;
                    stim_s  = 3'd0;
                end else begin
                    state_s = APPLY;
                    vec_s   = vec_r + 3'd1;
                    stim_s  = vec_r + 3'd1;
                end
`endif
            end
            default: begin
                state_s = IDLE;
                stim_s  = 3'd0;
            end
        endcase

        busy_s = (state_s == APPLY) || (state_s == SETTLE) || (state_s == CHECK);
        done_s = (state_s == DONE);
        pass_s = done_s && (err_s == 4'd0);
    end

    // State and output registers; reset drops everything to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            vec_r   <= 3'd0;
            cnt_r   <= 4'd0;
            err_r   <= 4'd0;
            fv_r    <= 3'd0;
            stim_r  <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            fv_r    <= fv_s;
            stim_r  <= stim_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
        end
    end

    assign dut_a    = stim_r[0];
    assign dut_b    = stim_r[1];
    assign dut_cin  = stim_r[2];
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_r;
    assign fail_vec = fv_r;

endmodule
